// File: rtl/mfrc522_spi_slave.sv
// SPI slave emulating the host-visible register interface of an NXP MFRC522.
// SPI pins are synchronized into clk; register file, SoftReset and FIFODataReg FIFO.
module mfrc522_spi_slave #(
   parameter logic [7:0]  VERSION    = 8'h92,
   parameter int unsigned FIFO_DEPTH = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic cs_n,
   input  logic sck,
   input  logic mosi,
   output logic miso
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;
   localparam int unsigned NREG  = 64;

   localparam logic [5:0] A_STATUS = 6'h00;
   localparam logic [5:0] A_CMD    = 6'h01;
   localparam logic [5:0] A_COMIEN = 6'h02;
   localparam logic [5:0] A_ERR    = 6'h06;
   localparam logic [5:0] A_FIFO   = 6'h09;
   localparam logic [5:0] A_LEVEL  = 6'h0A;
   localparam logic [5:0] A_VER    = 6'h37;

   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

   function automatic logic [7:0] reg_default(input logic [5:0] a);
      case (a)
         A_CMD:    return 8'h20;
         A_COMIEN: return 8'h80;
         A_VER:    return VERSION;
         default:  return 8'h00;
      endcase
   endfunction

   // Synchronizers reset to 0 so a chip select held low across rst never looks like a fall
   logic [1:0] cs_sync_q, sck_sync_q, mosi_sync_q;
   logic       cs_prev_q, sck_prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cs_sync_q   <= '0;
         sck_sync_q  <= '0;
         mosi_sync_q <= '0;
         cs_prev_q   <= 1'b0;
         sck_prev_q  <= 1'b0;
      end else begin
         cs_sync_q   <= {cs_sync_q[0], cs_n};
         sck_sync_q  <= {sck_sync_q[0], sck};
         mosi_sync_q <= {mosi_sync_q[0], mosi};
         cs_prev_q   <= cs_sync_q[1];
         sck_prev_q  <= sck_sync_q[1];
      end
   end

   logic cs_s, mosi_s, cs_fall_c, sck_rise_c, sck_fall_c;
   assign cs_s       = cs_sync_q[1];
   assign mosi_s     = mosi_sync_q[1];
   assign cs_fall_c  = cs_prev_q & ~cs_s;
   assign sck_rise_c = sck_sync_q[1] & ~sck_prev_q;
   assign sck_fall_c = ~sck_sync_q[1] & sck_prev_q;

   state_t             state_q, state_d;
   logic [2:0]         bit_cnt_q, bit_cnt_d;
   logic [7:0]         rx_q, rx_d, tx_q, tx_d;
   logic [5:0]         addr_q, addr_d;
   logic               rd_q, rd_d;
   logic               miso_q, miso_d;
   logic [7:0]         regs_q [NREG];
   logic [7:0]         fifo_mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
   logic [LVL_W-1:0]   level_q;
   logic               ovfl_q;

   logic [7:0] byte_c, ld_data_c;
   logic [5:0] ld_addr_c;
   logic       wr_en_c, ld_en_c, pop_c, push_c, fifo_full_c;

   assign fifo_full_c = (level_q >= LVL_W'(FIFO_DEPTH));
   assign push_c      = wr_en_c && (addr_q == A_FIFO) && !fifo_full_c;
   assign pop_c       = ld_en_c && (ld_addr_c == A_FIFO) && (level_q != '0);

   // Frame FSM: bit/byte tracking, register-access strobes, TX load and MISO shifting
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      rx_d      = rx_q;
      tx_d      = tx_q;
      addr_d    = addr_q;
      rd_d      = rd_q;
      miso_d    = miso_q;
      byte_c    = {rx_q[6:0], mosi_s};
      ld_addr_c = addr_q;
      ld_en_c   = 1'b0;
      wr_en_c   = 1'b0;
      ld_data_c = 8'h00;
      if (cs_s) begin
         state_d   = ST_IDLE;
         bit_cnt_d = 3'd0;
         rx_d      = 8'h00;
         tx_d      = 8'h00;
         miso_d    = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cs_fall_c) begin
                  state_d   = ST_ADDR;
                  bit_cnt_d = 3'd0;
                  rx_d      = 8'h00;
                  tx_d      = 8'h00;
                  miso_d    = 1'b0;
               end
            end
            default: begin
               if (sck_rise_c) begin
                  rx_d      = byte_c;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     if (state_q == ST_ADDR) begin
                        state_d   = ST_DATA;
                        rd_d      = byte_c[7];
                        addr_d    = byte_c[6:1];
                        ld_addr_c = byte_c[6:1];
                        ld_en_c   = byte_c[7];
                     end else if (rd_q) begin
                        ld_en_c = 1'b1;
                        if (byte_c[7]) ld_addr_c = byte_c[6:1];
                        addr_d = ld_addr_c;
                     end else begin
                        wr_en_c = 1'b1;
                     end
                  end
               end else if (sck_fall_c && (state_q == ST_DATA)) begin
                  miso_d = tx_q[7];
                  tx_d   = {tx_q[6:0], 1'b0};
               end
               if (ld_en_c) begin
                  case (ld_addr_c)
                     A_VER:   ld_data_c = VERSION;
                     A_LEVEL: ld_data_c = 8'(level_q);
                     A_ERR:   ld_data_c = {3'b000, ovfl_q, 4'b0000};
                     A_FIFO:  ld_data_c = (level_q == '0) ? 8'h00 : fifo_mem_q[rd_ptr_q];
                     default: ld_data_c = regs_q[ld_addr_c];
                  endcase
                  tx_d = ld_data_c;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= 3'd0;
         rx_q      <= 8'h00;
         tx_q      <= 8'h00;
         addr_q    <= 6'd0;
         rd_q      <= 1'b0;
         miso_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         rx_q      <= rx_d;
         tx_q      <= tx_d;
         addr_q    <= addr_d;
         rd_q      <= rd_d;
         miso_q    <= miso_d;
      end
   end

   // Register file, FIFO pointers and BufferOvfl; SoftReset behaves like rst for these
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= reg_default(6'(i));
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
         ovfl_q   <= 1'b0;
      end else begin
         if (wr_en_c) begin
            case (addr_q)
               A_STATUS, A_VER, A_ERR: begin
               end
               A_CMD: begin
                  if (byte_c[3:0] == 4'hF) begin
                     for (int i = 0; i < NREG; i++) regs_q[i] <= reg_default(6'(i));
                     rd_ptr_q <= '0;
                     wr_ptr_q <= '0;
                     level_q  <= '0;
                     ovfl_q   <= 1'b0;
                  end else begin
                     regs_q[A_CMD] <= byte_c;
                  end
               end
               A_FIFO: begin
                  if (fifo_full_c) begin
                     ovfl_q <= 1'b1;
                  end else begin
                     wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                     level_q  <= level_q + LVL_W'(1);
                  end
               end
               A_LEVEL: begin
                  if (byte_c[7]) begin
                     rd_ptr_q <= '0;
                     wr_ptr_q <= '0;
                     level_q  <= '0;
                     ovfl_q   <= 1'b0;
                  end
               end
               default: regs_q[addr_q] <= byte_c;
            endcase
         end
         if (pop_c) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q  <= level_q - LVL_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_c) fifo_mem_q[wr_ptr_q] <= byte_c;
   end

   assign miso = miso_q;

endmodule

// File: tb/tb_mfrc522_spi_slave.sv
// Directed bench for mfrc522_spi_slave: drives SPI mode-0 frames at clk/12.
module tb_mfrc522_spi_slave;

   logic clk = 1'b0;
   logic rst, cs_n, sck, mosi, miso;
   int   total = 0;
   int   passed = 0;
   logic [7:0] rx_buf [4];

   mfrc522_spi_slave #(.VERSION(8'h92), .FIFO_DEPTH(64)) dut (
      .clk(clk), .rst(rst), .cs_n(cs_n), .sck(sck), .mosi(mosi), .miso(miso)
   );

   always #5 clk = ~clk;

   task automatic wait_clks(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Mode 0: MISO sampled just before the SCK rise, MOSI set while SCK is low
   task automatic spi_bit(input logic b, output logic r);
      mosi = b;
      wait_clks(6);
      r = miso;
      sck = 1'b1;
      wait_clks(6);
      sck = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
      for (int i = 7; i >= 0; i--) spi_bit(b[i], r[i]);
   endtask

   task automatic frame(input logic [7:0] b0, b1, b2, b3, input int n);
      logic [7:0] tx [4];
      tx[0] = b0; tx[1] = b1; tx[2] = b2; tx[3] = b3;
      cs_n = 1'b0;
      wait_clks(6);
      for (int k = 0; k < n; k++) spi_byte(tx[k], rx_buf[k]);
      wait_clks(6);
      cs_n = 1'b1;
      wait_clks(6);
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      frame(a, d, 8'h00, 8'h00, 2);
   endtask

   task automatic rd(input logic [7:0] a, output logic [7:0] v);
      frame(a, 8'h00, 8'h00, 8'h00, 2);
      v = rx_buf[1];
   endtask

   task automatic test_reset;
      logic [7:0] v;
      rst = 1'b1; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0;
      wait_clks(4);
      total++;
      if (miso !== 1'b0) $display("FAIL reset_miso: got %b expected 0", miso); else passed++;
      rst = 1'b0;
      wait_clks(4);
      rd(8'h82, v);
      total++;
      if (v !== 8'h20) $display("FAIL reset_cmdreg: got %h expected 20", v); else passed++;
      total++;
      if (rx_buf[0] !== 8'h00) $display("FAIL addr_byte_miso: got %h expected 00", rx_buf[0]); else passed++;
      rd(8'h84, v);
      total++;
      if (v !== 8'h80) $display("FAIL reset_comien: got %h expected 80", v); else passed++;
      rd(8'h94, v);
      total++;
      if (v !== 8'h00) $display("FAIL reset_level: got %h expected 00", v); else passed++;
   endtask

   task automatic test_soft_reset;
      logic [7:0] v;
      wr(8'h02, 8'h05);
      rd(8'h82, v);
      total++;
      if (v !== 8'h05) $display("FAIL cmd_store: got %h expected 05", v); else passed++;
      wr(8'h12, 8'h99);
      rd(8'h94, v);
      total++;
      if (v !== 8'h01) $display("FAIL presoft_level: got %h expected 01", v); else passed++;
      wr(8'h02, 8'h0F);
      rd(8'h82, v);
      total++;
      if (v !== 8'h20) $display("FAIL softreset_cmd: got %h expected 20", v); else passed++;
      rd(8'h94, v);
      total++;
      if (v !== 8'h00) $display("FAIL softreset_level: got %h expected 00", v); else passed++;
   endtask

   task automatic test_version;
      logic [7:0] v;
      rd(8'hEE, v);
      total++;
      if (v !== 8'h92) $display("FAIL version: got %h expected 92", v); else passed++;
      wr(8'h6E, 8'h55);
      rd(8'hEE, v);
      total++;
      if (v !== 8'h92) $display("FAIL version_ro: got %h expected 92", v); else passed++;
   endtask

   task automatic test_fifo;
      logic [7:0] v;
      wr(8'h12, 8'hAB);
      rd(8'h94, v);
      total++;
      if (v !== 8'h01) $display("FAIL fifo_level1: got %h expected 01", v); else passed++;
      rd(8'h92, v);
      total++;
      if (v !== 8'hAB) $display("FAIL fifo_pop: got %h expected ab", v); else passed++;
      rd(8'h94, v);
      total++;
      if (v !== 8'h00) $display("FAIL fifo_level0: got %h expected 00", v); else passed++;
      rd(8'h92, v);
      total++;
      if (v !== 8'h00) $display("FAIL fifo_empty_pop: got %h expected 00", v); else passed++;
   endtask

   task automatic test_burst;
      logic [7:0] v;
      logic [7:0] exp [4];
      exp[1] = 8'h11; exp[2] = 8'h22; exp[3] = 8'h33;
      frame(8'h12, 8'h11, 8'h22, 8'h33, 4);
      rd(8'h94, v);
      total++;
      if (v !== 8'h03) $display("FAIL burst_level: got %h expected 03", v); else passed++;
      frame(8'h92, 8'h92, 8'h92, 8'h00, 4);
      for (int k = 1; k < 4; k++) begin
         total++;
         if (rx_buf[k] !== exp[k])
            $display("FAIL burst_data%0d: got %h expected %h", k, rx_buf[k], exp[k]);
         else passed++;
      end
      rd(8'h94, v);
      total++;
      if (v !== 8'h00) $display("FAIL burst_drained: got %h expected 00", v); else passed++;
   endtask

   task automatic test_overflow;
      logic [7:0] v;
      for (int k = 0; k < 65; k++) wr(8'h12, 8'h5A);
      rd(8'h94, v);
      total++;
      if (v !== 8'h40) $display("FAIL ovf_level: got %h expected 40", v); else passed++;
      rd(8'h8C, v);
      total++;
      if (v !== 8'h10) $display("FAIL ovf_error: got %h expected 10", v); else passed++;
      wr(8'h14, 8'h80);
      rd(8'h94, v);
      total++;
      if (v !== 8'h00) $display("FAIL flush_level: got %h expected 00", v); else passed++;
      rd(8'h8C, v);
      total++;
      if (v !== 8'h00) $display("FAIL flush_error: got %h expected 00", v); else passed++;
   endtask

   task automatic test_abort;
      logic [7:0] v;
      logic       b;
      wr(8'h12, 8'h77);
      rd(8'h94, v);
      total++;
      if (v !== 8'h01) $display("FAIL abort_prelevel: got %h expected 01", v); else passed++;
      cs_n = 1'b0;
      wait_clks(6);
      spi_byte(8'h12, v);
      for (int k = 0; k < 4; k++) spi_bit(1'b1, b);
      wait_clks(6);
      cs_n = 1'b1;
      wait_clks(6);
      rd(8'h94, v);
      total++;
      if (v !== 8'h01) $display("FAIL abort_level: got %h expected 01", v); else passed++;
      wr(8'h40, 8'h3C);
      rd(8'hC0, v);
      total++;
      if (v !== 8'h3C) $display("FAIL scratch: got %h expected 3c", v); else passed++;
   endtask

   task automatic test_rst_mid_frame;
      logic [7:0] v;
      logic       b;
      cs_n = 1'b0;
      wait_clks(6);
      spi_byte(8'h40, v);
      for (int k = 0; k < 3; k++) spi_bit(1'b1, b);
      rst = 1'b1;
      wait_clks(3);
      rst = 1'b0;
      for (int k = 0; k < 5; k++) spi_bit(1'b1, b);
      wait_clks(6);
      cs_n = 1'b1;
      wait_clks(6);
      rd(8'hC0, v);
      total++;
      if (v !== 8'h00) $display("FAIL rst_scratch: got %h expected 00", v); else passed++;
      rd(8'h94, v);
      total++;
      if (v !== 8'h00) $display("FAIL rst_level: got %h expected 00", v); else passed++;
   endtask

   initial begin
      test_reset;
      test_soft_reset;
      test_version;
      test_fifo;
      test_burst;
      test_overflow;
      test_abort;
      test_rst_mid_frame;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mfrc522_spi_slave.md
Name: mfrc522_spi_slave

Overview:
- Behavioural-synthesizable SPI slave that emulates the host-visible register interface of an NXP MFRC522 RFID reader.
- It is used as the peripheral on the SPI side of the SoC's AXI-to-SPI controller in integration benches.
- It samples the asynchronous SPI pins in the system clock domain.
- It implements a 64-entry register file, the VersionReg, SoftReset via CommandReg, and a byte FIFO behind FIFODataReg.

Parameters:
- VERSION, 8'h92, value returned by VersionReg (0x37).
- FIFO_DEPTH, 64, FIFO entries (8-bit each); level field is 7 bits.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- cs_n  input  1  SPI chip select, active low, asynchronous to clk.
- sck  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous; frequency at most clk/8.
- mosi  input  1  SPI data in, MSB first.
- miso  output  1  SPI data out, MSB first.

Behaviour:
- Synchronization:
  - cs_n, sck and mosi each pass through 2-flop synchronizers.
  - SCK rise and fall events are detected from the synchronized value versus its previous value.
  - All decoding is gated by synchronized cs_n low.
- Reset (rst=1):
  - miso=0, bit counter=0, shift registers=0, FIFO empty (level 0).
  - Registers load defaults: 0x01 CommandReg=0x20, 0x02 ComIEnReg=0x80, 0x06 ErrorReg=0x00, 0x0A FIFOLevelReg=0x00, 0x37 VersionReg=VERSION, all others 0x00.
- Frame:
  - Synchronized cs_n falling starts a frame: bit counter=0, byte index=0, miso=0.
  - MOSI is sampled on each SCK rise into an 8-bit shift register.
- Address byte (byte index 0):
  - bit7=1 means read, 0 means write.
  - bits6:1 = register address. bit0 is ignored.
  - miso stays 0 for the whole address byte.
- Write (byte index ≥1), on completion of each data byte at the 8th SCK rise:
  - The byte is written to the latched address. Burst bytes repeat to the same address.
- Read:
  - At completion of each byte, the value at the latched address is loaded into the TX shift register.
  - For a burst read, the address comes from the byte just received, if that byte's bit7=1; otherwise the previous address is kept.
  - miso takes TX bit7 at the next SCK fall, then shifts one bit per SCK fall.
  - The terminating byte in a burst read is typically 0x00; its data is ignored.
- Register semantics:
  - 0x00 and 0x37 are read-only (writes ignored). 0x37 always reads VERSION.
  - 0x01 CommandReg: writing low nibble 0xF (SoftReset) restores all register defaults and flushes the FIFO in the same cycle. CommandReg then reads 0x20. Other values are stored as written.
  - 0x09 FIFODataReg write: push if level<FIFO_DEPTH. If full, drop the byte and set ErrorReg bit4 (BufferOvfl).
  - 0x09 FIFODataReg read: pop the oldest byte at TX-load time. If empty, return 0x00 with no pop.
  - 0x0A FIFOLevelReg read: {1'b0, level[6:0]}. Write with bit7=1 flushes the FIFO (level 0) and clears ErrorReg bit4. Other bits are ignored.
  - 0x06 ErrorReg: read-only from SPI; bit4 as above, other bits 0.
  - All other addresses are plain read/write 8-bit storage.
- FIFO: circular buffer with wrap-around read/write pointers. Level 0..64.
- cs_n rising mid-byte: discard the partial byte with no write and no pop; miso=0; frame state cleared.
- rst asserted mid-frame: full reset as above. The frame is abandoned until the next cs_n fall.

Test Plan:
- SoftReset: send 0x02,0x0F; then read frame 0x82,0x00 -> miso byte 0x20; read 0x94,0x00 (0x0A) -> 0x00.
- Version: read frame 0xEE,0x00 -> 0x92. A write to 0x37 (0x6E,0x55) followed by a read still returns 0x92.
- FIFO round trip: write 0x12,0xAB; read 0x94,0x00 -> 0x01; read 0x92,0x00 -> 0xAB; read 0x94,0x00 -> 0x00; read 0x92,0x00 -> 0x00.
- Burst: write 0x12,0x11,0x22,0x33 -> level 3. Burst read 0x92,0x92,0x92,0x00 -> data bytes 0x11,0x22,0x33.
- Overflow/flush: 65 pushes of 0x5A -> level 0x40 and ErrorReg (0x8C) reads 0x10. Write 0x14,0x80 -> level 0x00 and ErrorReg 0x00.
- Abort: write 0x12 plus 4 SCK cycles, then deassert cs_n -> level unchanged. Scratch register 0x20: write 0x40,0x3C, read 0xC0,0x00 -> 0x3C. Asserting rst mid-frame -> 0x20 reads 0x00.
